// File: rtl/dso_acq_ctrl.sv
// Acquisition sequencer for the DSO capture path: walks each frame through
// stop, pre-trigger fill, trigger wait, post-trigger fill and display hold.
module dso_acq_ctrl #(
    parameter int HORIZONTAL   = 640,
    parameter int AUTO_TIMEOUT = 4096
) (
    input  logic        ad_clk,
    input  logic        rst,
    input  logic        deci_valid,
    input  logic        run_key,
    input  logic        single_key,
    input  logic        trig_mode,
    input  logic        trig_pulse_in,
    input  logic        ram_rd_over,
    output logic        wave_run,
    output logic        rearm,
    output logic        force_trig,
    output logic [2:0]  acq_state,
    output logic        single_mode,
    output logic [15:0] frame_cnt
);

    typedef enum logic [2:0] {
        ST_STOP = 3'd0,
        ST_PRE  = 3'd1,
        ST_WAIT = 3'd2,
        ST_POST = 3'd3,
        ST_HOLD = 3'd4
    } state_t;

    localparam logic [9:0]  HALF    = 10'(HORIZONTAL / 2);
    localparam logic [15:0] TIMEOUT = 16'(AUTO_TIMEOUT);

    state_t      state, state_nxt;
    logic [9:0]  smp_cnt, smp_nxt, smp_inc;
    logic [15:0] to_cnt, to_nxt, to_inc;
    logic [15:0] frame_nxt;
    logic        single_nxt, rearm_nxt, force_nxt;

    assign acq_state = state;
    assign smp_inc   = smp_cnt + 10'd1;
    assign to_inc    = to_cnt + 16'd1;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
        state_nxt  = state;
        smp_nxt    = smp_cnt;
        to_nxt     = to_cnt;
        frame_nxt  = frame_cnt;
        single_nxt = single_mode;
        rearm_nxt  = 1'b0;
        force_nxt  = 1'b0;

        if (state != ST_STOP && run_key) begin
            // Abort outranks every other transition and discards the partial frame.
            state_nxt  = ST_STOP;
            smp_nxt    = '0;
            to_nxt     = '0;
            single_nxt = 1'b0;
        end else begin
            case (state)
                ST_STOP: begin
                    if (run_key) begin
                        state_nxt  = ST_PRE;
                        single_nxt = 1'b0;
                    end else if (single_key) begin
                        state_nxt  = ST_PRE;
                        single_nxt = 1'b1;
                    end
                end
                ST_PRE: begin
                    if (deci_valid) begin
                        if (smp_inc == HALF) begin
                            state_nxt = ST_WAIT;
                            smp_nxt   = '0;
                            to_nxt    = '0;
                        end else begin
                            smp_nxt = smp_inc;
                        end
                    end
                end
                ST_WAIT: begin
                    if (deci_valid && trig_pulse_in) begin
                        state_nxt = ST_POST;
                        to_nxt    = '0;
                    end else if (!trig_mode) begin
                        to_nxt = '0;
                    end else if (deci_valid) begin
                        if (to_inc == TIMEOUT) begin
                            state_nxt = ST_POST;
                            force_nxt = 1'b1;
                            to_nxt    = '0;
                        end else begin
                            to_nxt = to_inc;
                        end
                    end
                end
                ST_POST: begin
                    if (deci_valid) begin
                        if (smp_inc == HALF) begin
                            state_nxt = ST_HOLD;
                            smp_nxt   = '0;
                            frame_nxt = frame_cnt + 16'd1;
                        end else begin
                            smp_nxt = smp_inc;
                        end
                    end
                end
                ST_HOLD: begin
                    if (ram_rd_over) begin
                        rearm_nxt = 1'b1;
                        if (single_mode) begin
                            state_nxt  = ST_STOP;
                            single_nxt = 1'b0;
                        end else begin
                            state_nxt = ST_PRE;
                        end
                    end
                end
                default: state_nxt = ST_STOP;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ad_clk) begin
        if (rst) begin
            state       <= ST_STOP;
            smp_cnt     <= '0;
            to_cnt      <= '0;
            frame_cnt   <= '0;
            single_mode <= 1'b0;
            rearm       <= 1'b0;
            force_trig  <= 1'b0;
            wave_run    <= 1'b0;
        end else begin
            state       <= state_nxt;
            smp_cnt     <= smp_nxt;
            to_cnt      <= to_nxt;
            frame_cnt   <= frame_nxt;
            single_mode <= single_nxt;
            rearm       <= rearm_nxt;
            force_trig  <= force_nxt;
            wave_run    <= (state_nxt != ST_STOP);
        end
    end

endmodule

// File: tb/tb_dso_acq_ctrl.sv
// Directed bench for dso_acq_ctrl: HORIZONTAL=640 (320-sample halves), AUTO_TIMEOUT=16.
module tb_dso_acq_ctrl;

    localparam logic [2:0] STOP = 3'd0, PRE = 3'd1, WAIT = 3'd2, POST = 3'd3, HOLD = 3'd4;

    logic        ad_clk = 1'b0;
    logic        rst = 1'b1;
    logic        deci_valid = 1'b0;
    logic        run_key = 1'b0;
    logic        single_key = 1'b0;
    logic        trig_mode = 1'b0;
    logic        trig_pulse_in = 1'b0;
    logic        ram_rd_over = 1'b0;
    logic        wave_run, rearm, force_trig, single_mode;
    logic [2:0]  acq_state;
    logic [15:0] frame_cnt;

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_frame = 16'd0;

    // {acq_state, wave_run, rearm, force_trig, single_mode}
    wire [6:0] flags = {acq_state, wave_run, rearm, force_trig, single_mode};

    dso_acq_ctrl #(.HORIZONTAL(640), .AUTO_TIMEOUT(16)) dut (
        .ad_clk        (ad_clk),
        .rst           (rst),
        .deci_valid    (deci_valid),
        .run_key       (run_key),
        .single_key    (single_key),
        .trig_mode     (trig_mode),
        .trig_pulse_in (trig_pulse_in),
        .ram_rd_over   (ram_rd_over),
        .wave_run      (wave_run),
        .rearm         (rearm),
        .force_trig    (force_trig),
        .acq_state     (acq_state),
        .single_mode   (single_mode),
        .frame_cnt     (frame_cnt)
    );

    always #5 ad_clk = ~ad_clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge ad_clk);
            #1;
        end
    endtask

    task automatic press_run();
        run_key = 1'b1;
        tick();
        run_key = 1'b0;
    endtask

    task automatic pulse_trig();
        trig_pulse_in = 1'b1;
        tick();
        trig_pulse_in = 1'b0;
    endtask

    task automatic pulse_rd_over();
        ram_rd_over = 1'b1;
        tick();
        ram_rd_over = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        deci_valid = 1'b1;
        tick(2);
        checks++;
        if (flags !== {STOP, 4'b0000}) begin
            failures++; $display("FAIL reset_flags: got=%b exp=%b", flags, {STOP, 4'b0000});
        end
        checks++;
        if (frame_cnt !== 16'd0) begin
            failures++; $display("FAIL reset_frame: got=%0d exp=0", frame_cnt);
        end
        rst = 1'b0;
        tick(3);
        checks++;
        if (flags !== {STOP, 4'b0000}) begin
            failures++; $display("FAIL idle_stop: got=%b exp=%b", flags, {STOP, 4'b0000});
        end
    endtask

    task automatic test_normal_frame();
        trig_mode = 1'b0;
        deci_valid = 1'b1;
        press_run();
        checks++;
        if (flags !== {PRE, 4'b1000}) begin
            failures++; $display("FAIL run_start: got=%b exp=%b", flags, {PRE, 4'b1000});
        end
        tick(319);
        checks++;
        if (acq_state !== PRE) begin
            failures++; $display("FAIL pre_319: got=%0d exp=%0d", acq_state, PRE);
        end
        tick();
        checks++;
        if (acq_state !== WAIT) begin
            failures++; $display("FAIL wait_entry: got=%0d exp=%0d", acq_state, WAIT);
        end
        deci_valid = 1'b0;
        pulse_trig();
        deci_valid = 1'b1;
        checks++;
        if (acq_state !== WAIT) begin
            failures++; $display("FAIL trig_no_valid: got=%0d exp=%0d", acq_state, WAIT);
        end
        tick(179);
        checks++;
        if (acq_state !== WAIT) begin
            failures++; $display("FAIL wait_499: got=%0d exp=%0d", acq_state, WAIT);
        end
        pulse_trig();
        checks++;
        if (flags !== {POST, 4'b1000}) begin
            failures++; $display("FAIL post_entry: got=%b exp=%b", flags, {POST, 4'b1000});
        end
        tick(319);
        checks++;
        if (acq_state !== POST) begin
            failures++; $display("FAIL post_319: got=%0d exp=%0d", acq_state, POST);
        end
        tick();
        exp_frame = exp_frame + 16'd1;
        checks++;
        if (acq_state !== HOLD || frame_cnt !== exp_frame) begin
            failures++; $display("FAIL hold_entry: state=%0d frame=%0d exp state=%0d frame=%0d", acq_state, frame_cnt, HOLD, exp_frame);
        end
        tick(3);
        checks++;
        if (flags !== {HOLD, 4'b1000}) begin
            failures++; $display("FAIL hold_wait: got=%b exp=%b", flags, {HOLD, 4'b1000});
        end
        pulse_rd_over();
        checks++;
        if (flags !== {PRE, 4'b1100}) begin
            failures++; $display("FAIL rearm_pulse: got=%b exp=%b", flags, {PRE, 4'b1100});
        end
        tick();
        checks++;
        if (flags !== {PRE, 4'b1000}) begin
            failures++; $display("FAIL rearm_one_cycle: got=%b exp=%b", flags, {PRE, 4'b1000});
        end
        pulse_rd_over();
        checks++;
        if (flags !== {PRE, 4'b1000}) begin
            failures++; $display("FAIL rd_over_in_pre: got=%b exp=%b", flags, {PRE, 4'b1000});
        end
        single_key = 1'b1;
        tick();
        single_key = 1'b0;
        checks++;
        if (flags !== {PRE, 4'b1000}) begin
            failures++; $display("FAIL single_ignored: got=%b exp=%b", flags, {PRE, 4'b1000});
        end
        press_run();
        checks++;
        if (flags !== {STOP, 4'b0000} || frame_cnt !== exp_frame) begin
            failures++; $display("FAIL stop_from_pre: flags=%b frame=%0d exp flags=%b frame=%0d", flags, frame_cnt, {STOP, 4'b0000}, exp_frame);
        end
    endtask

    task automatic test_auto_timeout();
        trig_mode = 1'b1;
        press_run();
        tick(320);
        tick(15);
        checks++;
        if (flags !== {WAIT, 4'b1000}) begin
            failures++; $display("FAIL auto_15: got=%b exp=%b", flags, {WAIT, 4'b1000});
        end
        tick();
        checks++;
        if (flags !== {POST, 4'b1010}) begin
            failures++; $display("FAIL force_trig: got=%b exp=%b", flags, {POST, 4'b1010});
        end
        tick();
        checks++;
        if (flags !== {POST, 4'b1000}) begin
            failures++; $display("FAIL force_one_cycle: got=%b exp=%b", flags, {POST, 4'b1000});
        end
        press_run();
        checks++;
        if (flags !== {STOP, 4'b0000} || frame_cnt !== exp_frame) begin
            failures++; $display("FAIL auto_abort: flags=%b frame=%0d exp frame=%0d", flags, frame_cnt, exp_frame);
        end
    endtask

    task automatic test_auto_restart();
        trig_mode = 1'b1;
        press_run();
        tick(320);
        tick(10);
        trig_mode = 1'b0;
        tick();
        trig_mode = 1'b1;
        tick(15);
        checks++;
        if (flags !== {WAIT, 4'b1000}) begin
            failures++; $display("FAIL mode_restart: got=%b exp=%b", flags, {WAIT, 4'b1000});
        end
        tick();
        checks++;
        if (flags !== {POST, 4'b1010}) begin
            failures++; $display("FAIL restart_force: got=%b exp=%b", flags, {POST, 4'b1010});
        end
        press_run();
    endtask

    task automatic test_auto_trig_wins();
        trig_mode = 1'b1;
        press_run();
        tick(320);
        tick(15);
        pulse_trig();
        checks++;
        if (flags !== {POST, 4'b1000}) begin
            failures++; $display("FAIL trig_beats_timeout: got=%b exp=%b", flags, {POST, 4'b1000});
        end
        tick();
        checks++;
        if (force_trig !== 1'b0) begin
            failures++; $display("FAIL no_late_force: got=%b exp=0", force_trig);
        end
        press_run();
        trig_mode = 1'b0;
    endtask

    task automatic test_single_shot();
        single_key = 1'b1;
        tick();
        single_key = 1'b0;
        checks++;
        if (flags !== {PRE, 4'b1001}) begin
            failures++; $display("FAIL single_start: got=%b exp=%b", flags, {PRE, 4'b1001});
        end
        tick(320);
        pulse_trig();
        tick(320);
        exp_frame = exp_frame + 16'd1;
        checks++;
        if (flags !== {HOLD, 4'b1001} || frame_cnt !== exp_frame) begin
            failures++; $display("FAIL single_hold: flags=%b frame=%0d exp flags=%b frame=%0d", flags, frame_cnt, {HOLD, 4'b1001}, exp_frame);
        end
        pulse_rd_over();
        checks++;
        if (flags !== {STOP, 4'b0100}) begin
            failures++; $display("FAIL single_end: got=%b exp=%b", flags, {STOP, 4'b0100});
        end
        tick();
        pulse_rd_over();
        checks++;
        if (flags !== {STOP, 4'b0000}) begin
            failures++; $display("FAIL second_rd_over: got=%b exp=%b", flags, {STOP, 4'b0000});
        end
    endtask

    task automatic test_abort_post();
        press_run();
        tick(320);
        pulse_trig();
        tick(99);
        press_run();
        checks++;
        if (flags !== {STOP, 4'b0000} || frame_cnt !== exp_frame) begin
            failures++; $display("FAIL post_abort: flags=%b frame=%0d exp flags=%b frame=%0d", flags, frame_cnt, {STOP, 4'b0000}, exp_frame);
        end
        press_run();
        tick(319);
        checks++;
        if (acq_state !== PRE) begin
            failures++; $display("FAIL cleared_pre_319: got=%0d exp=%0d", acq_state, PRE);
        end
        tick();
        checks++;
        if (acq_state !== WAIT) begin
            failures++; $display("FAIL cleared_pre_320: got=%0d exp=%0d", acq_state, WAIT);
        end
        press_run();
    endtask

    task automatic test_both_keys_and_reset();
        run_key = 1'b1;
        single_key = 1'b1;
        tick();
        run_key = 1'b0;
        single_key = 1'b0;
        checks++;
        if (flags !== {PRE, 4'b1000}) begin
            failures++; $display("FAIL both_keys: got=%b exp=%b", flags, {PRE, 4'b1000});
        end
        tick(320);
        checks++;
        if (acq_state !== WAIT) begin
            failures++; $display("FAIL both_wait: got=%0d exp=%0d", acq_state, WAIT);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_frame = 16'd0;
        checks++;
        if (flags !== {STOP, 4'b0000} || frame_cnt !== exp_frame) begin
            failures++; $display("FAIL rst_in_wait: flags=%b frame=%0d exp flags=%b frame=0", flags, frame_cnt, {STOP, 4'b0000});
        end
    endtask

    initial begin
        test_reset();
        test_normal_frame();
        test_auto_timeout();
        test_auto_restart();
        test_auto_trig_wins();
        test_single_shot();
        test_abort_post();
        test_both_keys_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dso_acq_ctrl.md
# dso_acq_ctrl

Acquisition sequencer for the DSO capture path. It runs on `ad_clk` and walks each frame through stop, pre-trigger fill, trigger wait, post-trigger fill and display hold. It drives the capture store's `wave_run` enable and its frame re-arm pulse, and it synthesises a forced trigger in auto mode so the screen keeps updating without a valid edge. It sits between the front-panel key logic and the capture store, and counts `deci_valid` samples itself so that its frame boundaries line up with the store's.

## Interface
Parameters:
- `HORIZONTAL`, 640: samples per frame; even, at most 1023; pre-trigger and post-trigger depth are each `HORIZONTAL/2`.
- `AUTO_TIMEOUT`, 4096: `deci_valid` samples spent in WAIT before an auto-mode forced trigger; range 1..65535.

Ports:
- `ad_clk`  in  1  sole clock.
- `rst`  in  1  reset; synchronous, active-high.
- `deci_valid`  in  1  sample strobe; the only event that advances the sample counters.
- `run_key`  in  1  one-cycle pulse; toggles run/stop.
- `single_key`  in  1  one-cycle pulse; requests one single-shot frame.
- `trig_mode`  in  1  0 = normal, 1 = auto.
- `trig_pulse_in`  in  1  trigger condition from the store's edge detector.
- `ram_rd_over`  in  1  display finished reading the frame; already synchronised to `ad_clk`.
- `wave_run`  out  1  capture enable to the store.
- `rearm`  out  1  one-cycle pulse; frame consumed, store restarts its count.
- `force_trig`  out  1  one-cycle pulse; auto-mode forced trigger.
- `acq_state`  out  3  state code: STOP=0, PRE=1, WAIT=2, POST=3, HOLD=4.
- `single_mode`  out  1  current run is single-shot.
- `frame_cnt`  out  16  frames completed; wraps 65535 -> 0.

## Operation
- All outputs are registered.
- Reset values: `acq_state`=STOP, `wave_run`=0, `rearm`=0, `force_trig`=0, `single_mode`=0, `frame_cnt`=0. Internal `smp_cnt` (10 bit) and `to_cnt` (16 bit) are 0.
- **STOP**
  - `wave_run`=0.
  - `run_key` -> PRE with `single_mode`=0.
  - Else `single_key` -> PRE with `single_mode`=1.
  - If both keys arrive in the same cycle, `run_key` wins.
- **PRE**
  - `smp_cnt` increments on `deci_valid`.
  - When the increment reaches `HORIZONTAL/2` -> WAIT; `smp_cnt` clears to 0 and `to_cnt` clears to 0.
- **WAIT**
  - `trig_pulse_in` && `deci_valid` -> POST.
  - `trig_pulse_in` without `deci_valid` is ignored.
  - With `trig_mode`=1, `to_cnt` increments on each `deci_valid` that has no trigger.
  - When `to_cnt` reaches `AUTO_TIMEOUT` -> POST, with `force_trig`=1 for that one transition cycle.
  - With `trig_mode`=0, `to_cnt` is held at 0; switching mode mid-WAIT restarts the timeout from 0.
  - A real trigger and the timeout in the same cycle: the real trigger wins and no `force_trig` is issued.
- **POST**
  - `smp_cnt` increments on `deci_valid`.
  - Reaching `HORIZONTAL/2` -> HOLD; `smp_cnt` clears to 0 and `frame_cnt` increments.
- **HOLD**
  - `wave_run` stays 1 so the store accepts the re-arm.
  - On `ram_rd_over`: `rearm`=1 for one cycle.
  - If `single_mode`=1 -> STOP and `single_mode` clears; otherwise -> PRE.
- `wave_run`=1 in every state except STOP.
- `run_key` in any non-STOP state -> STOP next cycle, with `smp_cnt`, `to_cnt` and `single_mode` cleared and no `rearm`.
  - This has priority over every other transition in the same cycle.
  - A frame aborted in POST does not increment `frame_cnt`.
- `single_key` outside STOP is ignored.
- `frame_cnt` increments only on the POST -> HOLD transition.

## Timing
- A key pulse at edge N gives the new `acq_state` and `wave_run` at edge N+1; no other latency.
- PRE -> WAIT occurs on the edge that registers the `HORIZONTAL/2`-th `deci_valid` of PRE.
- POST -> HOLD occurs on the edge that registers the `HORIZONTAL/2`-th `deci_valid` of POST.
- The trigger sample itself is not counted in POST.
- `force_trig` and `rearm` are high for exactly one cycle and never assert back-to-back.
- `rearm` is high in the same cycle that `acq_state` shows the HOLD successor.
- `ram_rd_over` is sampled only in HOLD; pulses in any other state are dropped.
- `rst` asserted mid-frame returns all outputs to their reset values at the next edge, whatever the state.
- Minimum frame length: `HORIZONTAL`+1 `deci_valid` cycles plus 1 HOLD cycle.

## Test plan
- Reset, then `run_key`; `deci_valid` always 1; `trig_pulse_in` at sample 500 -> WAIT entered after 320 samples, POST at sample 500, HOLD 320 samples later, `frame_cnt`=1; `ram_rd_over` -> `rearm` pulse and `acq_state`=1.
- Auto mode, `AUTO_TIMEOUT`=16, no trigger -> `force_trig` pulse exactly 16 `deci_valid` after WAIT entry, then POST.
- Same setup with `trig_pulse_in` arriving on the 16th sample -> POST and no `force_trig`.
- `single_key` in STOP, full frame, `ram_rd_over` -> `rearm` pulse, `acq_state`=0, `wave_run`=0, `single_mode`=0; a second `ram_rd_over` -> no pulse.
- `run_key` while in POST at sample 100 -> STOP next cycle, `frame_cnt` unchanged, no `rearm`.
- `run_key` and `single_key` in the same cycle from STOP -> PRE with `single_mode`=0; `rst` pulse in WAIT -> all outputs return to reset values.
